// File: rtl/riscv_pipeline_control_if.sv
// Bundle of hazard inputs and pipeline-control outputs shared by the
// in-order pipeline datapath and its control block.
interface riscv_pipeline_control_if #(
  parameter int CNT_W = 16
);
  logic             i_fetch_valid;
  logic [4:0]       i_id_rs1;
  logic [4:0]       i_id_rs2;
  logic             i_id_rs1_used;
  logic             i_id_rs2_used;
  logic [4:0]       i_ex_rd;
  logic             i_ex_is_load;
  logic             i_ex_branch_taken;
  logic             i_ex_mc_start;
  logic             i_ex_mc_done;
  logic             i_mem_stall;
  logic             o_pc_en;
  logic             o_if_id_en;
  logic             o_id_ex_en;
  logic             o_ex_mem_en;
  logic             o_mem_wb_en;
  logic             o_if_id_flush;
  logic             o_id_ex_flush;
  logic             o_valid_id;
  logic             o_valid_ex;
  logic             o_valid_mem;
  logic             o_valid_wb;
  logic [CNT_W-1:0] o_stall_cnt;

  modport slave (
    input  i_fetch_valid, i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
           i_ex_rd, i_ex_is_load, i_ex_branch_taken, i_ex_mc_start,
           i_ex_mc_done, i_mem_stall,
    output o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en,
           o_if_id_flush, o_id_ex_flush, o_valid_id, o_valid_ex,
           o_valid_mem, o_valid_wb, o_stall_cnt
  );

  modport master (
    output i_fetch_valid, i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
           i_ex_rd, i_ex_is_load, i_ex_branch_taken, i_ex_mc_start,
           i_ex_mc_done, i_mem_stall,
    input  o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en,
           o_if_id_flush, o_id_ex_flush, o_valid_id, o_valid_ex,
           o_valid_mem, o_valid_wb, o_stall_cnt
  );
endinterface

// File: rtl/riscv_pipeline_control.sv
// Hazard/stall control for a 5-stage in-order RISC-V pipeline: stage enables,
// bubble injection, per-stage valid tracking and a saturating stall counter.
module riscv_pipeline_control #(
  parameter int CNT_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  riscv_pipeline_control_if.slave  bus
);

  typedef enum logic {RUN, MC_BUSY} state_t;

  state_t           state, state_next;
  logic             valid_id, valid_ex, valid_mem, valid_wb;
  logic [CNT_W-1:0] stall_cnt;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, mem_bubble;
  logic mc_busy, branch, load_use, rs1_hit, rs2_hit;

  // Hazard detection; EX-side requests only count when EX holds a real instruction
  assign mc_busy  = (state == MC_BUSY) && !bus.i_ex_mc_done;
  assign branch   = bus.i_ex_branch_taken && valid_ex;
  assign rs1_hit  = bus.i_id_rs1_used && (bus.i_id_rs1 == bus.i_ex_rd);
  assign rs2_hit  = bus.i_id_rs2_used && (bus.i_id_rs2 == bus.i_ex_rd);
  assign load_use = valid_ex && bus.i_ex_is_load && (bus.i_ex_rd != 5'd0) &&
                    valid_id && (rs1_hit || rs2_hit);

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    mem_bubble  = 1'b0;
    if (bus.i_mem_stall) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (mc_busy) begin
      // Multi-cycle op holds EX; MEM drains and receives bubbles
      pc_en      = 1'b0;
      if_id_en   = 1'b0;
      id_ex_en   = 1'b0;
      mem_bubble = 1'b1;
    end else if (branch) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      RUN:     if (bus.i_ex_mc_start && valid_ex && !bus.i_mem_stall) state_next = MC_BUSY;
      MC_BUSY: if (bus.i_ex_mc_done) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Stage boundary: FSM, valid shift chain and stall counter
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= RUN;
      valid_id  <= 1'b0;
      valid_ex  <= 1'b0;
      valid_mem <= 1'b0;
      valid_wb  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_next;
      if (if_id_en)  valid_id  <= if_id_flush ? 1'b0 : bus.i_fetch_valid;
      if (id_ex_en)  valid_ex  <= id_ex_flush ? 1'b0 : valid_id;
      if (ex_mem_en) valid_mem <= mem_bubble  ? 1'b0 : valid_ex;
      if (mem_wb_en) valid_wb  <= valid_mem;
      if (!pc_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.o_pc_en       = pc_en;
  assign bus.o_if_id_en    = if_id_en;
  assign bus.o_id_ex_en    = id_ex_en;
  assign bus.o_ex_mem_en   = ex_mem_en;
  assign bus.o_mem_wb_en   = mem_wb_en;
  assign bus.o_if_id_flush = if_id_flush;
  assign bus.o_id_ex_flush = id_ex_flush;
  assign bus.o_valid_id    = valid_id;
  assign bus.o_valid_ex    = valid_ex;
  assign bus.o_valid_mem   = valid_mem;
  assign bus.o_valid_wb    = valid_wb;
  assign bus.o_stall_cnt   = stall_cnt;

endmodule

// File: tb/tb_riscv_pipeline_control.sv
// Directed hazard scenarios followed by randomized traffic, all checked
// against a cycle-level behavioural model of the pipeline control rules.
module tb_riscv_pipeline_control;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  riscv_pipeline_control_if #(.CNT_W(CNT_W)) bus ();
  riscv_pipeline_control #(.CNT_W(CNT_W)) dut (.i_clk(clk), .i_rstn(rstn), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  // Model state: m_v[0..3] = valid in ID, EX, MEM, WB
  bit [3:0] m_v;
  bit       m_busy;
  int       m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Returns {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, mem_bubble}
  function automatic logic [7:0] model_ctl();
    bit br = bus.i_ex_branch_taken && m_v[1];
    bit lu = m_v[1] && bus.i_ex_is_load && (bus.i_ex_rd != 5'd0) && m_v[0] &&
             ((bus.i_id_rs1_used && bus.i_id_rs1 == bus.i_ex_rd) ||
              (bus.i_id_rs2_used && bus.i_id_rs2 == bus.i_ex_rd));
    if (bus.i_mem_stall)              return 8'b0000_0000;
    if (m_busy && !bus.i_ex_mc_done)  return 8'b0001_1001;
    if (br)                           return 8'b1111_1110;
    if (lu)                           return 8'b0011_1010;
    return 8'b1111_1000;
  endfunction

  task automatic model_step(input logic [7:0] e);
    bit [3:0] nv = m_v;
    if (e[3]) nv[3] = m_v[2];
    if (e[4]) nv[2] = e[0] ? 1'b0 : m_v[1];
    if (e[5]) nv[1] = e[1] ? 1'b0 : m_v[0];
    if (e[6]) nv[0] = e[2] ? 1'b0 : bus.i_fetch_valid;
    if (!m_busy) m_busy = bus.i_ex_mc_start && m_v[1] && !bus.i_mem_stall;
    else         m_busy = !bus.i_ex_mc_done;
    if (!e[7] && m_cnt < CNT_MAX) m_cnt++;
    m_v = nv;
  endtask

  // Called at a falling edge with inputs already applied; ends at the next falling edge
  task automatic tick();
    logic [7:0] e;
    #1;
    e = model_ctl();
    chk("pc_en",       32'(bus.o_pc_en),       32'(e[7]));
    chk("if_id_en",    32'(bus.o_if_id_en),    32'(e[6]));
    chk("id_ex_en",    32'(bus.o_id_ex_en),    32'(e[5]));
    chk("ex_mem_en",   32'(bus.o_ex_mem_en),   32'(e[4]));
    chk("mem_wb_en",   32'(bus.o_mem_wb_en),   32'(e[3]));
    chk("if_id_flush", 32'(bus.o_if_id_flush), 32'(e[2]));
    chk("id_ex_flush", 32'(bus.o_id_ex_flush), 32'(e[1]));
    chk("valid_id",    32'(bus.o_valid_id),    32'(m_v[0]));
    chk("valid_ex",    32'(bus.o_valid_ex),    32'(m_v[1]));
    chk("valid_mem",   32'(bus.o_valid_mem),   32'(m_v[2]));
    chk("valid_wb",    32'(bus.o_valid_wb),    32'(m_v[3]));
    chk("stall_cnt",   32'(bus.o_stall_cnt),   m_cnt);
    @(posedge clk);
    model_step(e);
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between clock edges; checks the immediate effect
  task automatic mid_reset();
    #2 rstn = 1'b0;
    #1;
    m_v = '0; m_busy = 1'b0; m_cnt = 0;
    chk("rst_valid_id",  32'(bus.o_valid_id),  0);
    chk("rst_valid_ex",  32'(bus.o_valid_ex),  0);
    chk("rst_valid_mem", 32'(bus.o_valid_mem), 0);
    chk("rst_valid_wb",  32'(bus.o_valid_wb),  0);
    chk("rst_stall_cnt", 32'(bus.o_stall_cnt), 0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic clear_inputs();
    bus.i_fetch_valid = 1'b1;
    bus.i_id_rs1 = '0; bus.i_id_rs2 = '0;
    bus.i_id_rs1_used = 1'b0; bus.i_id_rs2_used = 1'b0;
    bus.i_ex_rd = '0; bus.i_ex_is_load = 1'b0;
    bus.i_ex_branch_taken = 1'b0;
    bus.i_ex_mc_start = 1'b0; bus.i_ex_mc_done = 1'b0;
    bus.i_mem_stall = 1'b0;
  endtask

  initial begin
    int c0;
    clear_inputs();
    bus.i_fetch_valid = 1'b0;
    m_v = '0; m_busy = 1'b0; m_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_valid_wb", 32'(bus.o_valid_wb),  0);
    chk("reset_cnt",      32'(bus.o_stall_cnt), 0);
    chk("reset_pc_en",    32'(bus.o_pc_en),     1);
    rstn = 1'b1;

    // Fill
    clear_inputs();
    tick();
    chk("fill1_id", 32'(bus.o_valid_id), 1);
    chk("fill1_ex", 32'(bus.o_valid_ex), 0);
    tick(); tick(); tick();
    chk("fill4_wb",  32'(bus.o_valid_wb),  1);
    chk("fill4_cnt", 32'(bus.o_stall_cnt), 0);

    // Load-use on rs1
    bus.i_ex_is_load = 1'b1; bus.i_ex_rd = 5'd5; bus.i_id_rs1 = 5'd5; bus.i_id_rs1_used = 1'b1;
    #1;
    chk("lu_pc_en", 32'(bus.o_pc_en),       0);
    chk("lu_flush", 32'(bus.o_id_ex_flush), 1);
    tick();
    chk("lu_valid_ex", 32'(bus.o_valid_ex),  0);
    chk("lu_cnt",      32'(bus.o_stall_cnt), 1);
    clear_inputs();
    tick();

    // Load to x0 never stalls
    bus.i_ex_is_load = 1'b1; bus.i_ex_rd = 5'd0; bus.i_id_rs1 = 5'd0; bus.i_id_rs1_used = 1'b1;
    #1;
    chk("x0_pc_en", 32'(bus.o_pc_en), 1);
    tick();

    // Branch together with load-use: branch wins
    bus.i_ex_branch_taken = 1'b1;
    bus.i_ex_is_load = 1'b1; bus.i_ex_rd = 5'd5; bus.i_id_rs1 = 5'd5; bus.i_id_rs1_used = 1'b1;
    #1;
    chk("br_pc_en",    32'(bus.o_pc_en),       1);
    chk("br_if_flush", 32'(bus.o_if_id_flush), 1);
    chk("br_id_flush", 32'(bus.o_id_ex_flush), 1);
    tick();
    chk("br_valid_id", 32'(bus.o_valid_id),  0);
    chk("br_valid_ex", 32'(bus.o_valid_ex),  0);
    chk("br_cnt",      32'(bus.o_stall_cnt), 1);
    clear_inputs();
    tick(); tick();

    // Multi-cycle op: three busy cycles before done
    c0 = 1;
    bus.i_ex_mc_start = 1'b1;
    tick();
    bus.i_ex_mc_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("mc_pc_en", 32'(bus.o_pc_en), 0);
      tick();
      chk("mc_bubble", 32'(bus.o_valid_mem), 0);
    end
    bus.i_ex_mc_done = 1'b1;
    #1 chk("mc_done_pc_en", 32'(bus.o_pc_en), 1);
    tick();
    bus.i_ex_mc_done = 1'b0;
    chk("mc_cnt", 32'(bus.o_stall_cnt), c0 + 3);

    // Memory stall during a multi-cycle op
    bus.i_ex_mc_start = 1'b1;
    tick();
    bus.i_ex_mc_start = 1'b0;
    tick();
    bus.i_mem_stall = 1'b1;
    #1;
    chk("ms_pc_en",     32'(bus.o_pc_en),     0);
    chk("ms_ex_mem_en", 32'(bus.o_ex_mem_en), 0);
    chk("ms_mem_wb_en", 32'(bus.o_mem_wb_en), 0);
    tick(); tick();
    chk("ms_cnt", 32'(bus.o_stall_cnt), c0 + 3 + 1 + 2);
    bus.i_mem_stall = 1'b0;
    bus.i_ex_mc_done = 1'b1;
    tick();
    bus.i_ex_mc_done = 1'b0;

    // Saturation, then asynchronous reset while busy and stalled
    bus.i_ex_mc_start = 1'b1;
    tick();
    bus.i_ex_mc_start = 1'b0;
    bus.i_mem_stall = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_cnt", 32'(bus.o_stall_cnt), CNT_MAX);
    bus.i_mem_stall = 1'b0;
    mid_reset();
    chk("post_rst_pc_en", 32'(bus.o_pc_en), 1);
    tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bus.i_fetch_valid     = ($urandom_range(7) != 0);
      bus.i_id_rs1          = 5'($urandom_range(3));
      bus.i_id_rs2          = 5'($urandom_range(3));
      bus.i_id_rs1_used     = $urandom_range(1) == 1;
      bus.i_id_rs2_used     = $urandom_range(1) == 1;
      bus.i_ex_rd           = 5'($urandom_range(3));
      bus.i_ex_is_load      = ($urandom_range(2) == 0);
      bus.i_ex_branch_taken = ($urandom_range(7) == 0);
      bus.i_ex_mc_start     = ($urandom_range(9) == 0);
      bus.i_ex_mc_done      = m_busy ? ($urandom_range(3) == 0) : ($urandom_range(7) == 0);
      bus.i_mem_stall       = ($urandom_range(7) == 0);
      if ($urandom_range(99) == 0) mid_reset();
      else                          tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
